// File: rtl/rsa_sched_pkg.sv
// Shared types and constants for the RSA job scheduler.
package rsa_sched_pkg;

    localparam int unsigned NREQ = 2;
    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/rsa_scheduler_if.sv
// Requester-side and datapath-side signals of the RSA scheduler.
interface rsa_scheduler_if
    import rsa_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] p_in;
    logic [NREQ*WIDTH-1:0] e_in;
    logic [NREQ*WIDTH-1:0] m_in;
    logic [NREQ*WIDTH-1:0] const_in;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      result;
    logic                  err;
    logic                  busy;
    logic                  rsa_ena;
    logic                  rsa_clear;
    logic [WIDTH-1:0]      rsa_p;
    logic [WIDTH-1:0]      rsa_e;
    logic [WIDTH-1:0]      rsa_m;
    logic [WIDTH-1:0]      rsa_const;
    logic [WIDTH-1:0]      rsa_c;
    logic                  rsa_eoc;

    // Scheduler view.
    modport slave (
        input  req, p_in, e_in, m_in, const_in, rsa_c, rsa_eoc,
        output gnt, done, result, err, busy,
               rsa_ena, rsa_clear, rsa_p, rsa_e, rsa_m, rsa_const
    );

    // Requesters plus datapath view.
    modport master (
        output req, p_in, e_in, m_in, const_in, rsa_c, rsa_eoc,
        input  gnt, done, result, err, busy,
               rsa_ena, rsa_clear, rsa_p, rsa_e, rsa_m, rsa_const
    );

endinterface

// File: rtl/rsa_rr_arbiter.sv
// Combinational round-robin selector: search starts just after the last owner.
module rsa_rr_arbiter
    import rsa_sched_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last_grant,
    output logic [NREQ-1:0] grant
);

    logic [IDXW-1:0] idx;
    logic            found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IDXW'((32'(last_grant) + k) % NREQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rsa_scheduler.sv
// Arbitrates two requesters onto one RSA datapath and supervises each job
// with a start pulse, end-of-conversion capture and a run-time watchdog.
module rsa_scheduler
    import rsa_sched_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 1023
) (
    input logic            clk,
    input logic            rst,
    rsa_scheduler_if.slave bus
);

    localparam int unsigned   TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [NREQ-1:0]   arb_grant;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   done_v;
    logic [IDXW-1:0]   last_grant;
    logic [IDXW-1:0]   owner;
    logic [IDXW-1:0]   sel;
    logic [TW-1:0]     timer;
    logic              timed_out;
    logic              ena;
    logic              clear;
    logic              err_q;
    logic [WIDTH-1:0]  result_q;
    logic [WIDTH-1:0]  p_sel, e_sel, m_sel, k_sel;
    logic [WIDTH-1:0]  p_q, e_q, m_q, k_q;

    assign timed_out = (timer == T_LAST);

    rsa_rr_arbiter u_arb (
        .req        (bus.req),
        .last_grant (last_grant),
        .grant      (arb_grant)
    );

    always_comb begin
        sel   = '0;
        p_sel = '0;
        e_sel = '0;
        m_sel = '0;
        k_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                sel   = IDXW'(i);
                p_sel = bus.p_in[i*WIDTH +: WIDTH];
                e_sel = bus.e_in[i*WIDTH +: WIDTH];
                m_sel = bus.m_in[i*WIDTH +: WIDTH];
                k_sel = bus.const_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // eoc is not looked at in START; it only matters once RUN is reached.
    always_comb begin
        state_nxt = state;
        ena       = 1'b0;
        clear     = 1'b0;
        done_v    = '0;
        unique case (state)
            IDLE:  if (|bus.req) state_nxt = START;
            START: begin
                ena       = 1'b1;
                clear     = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                ena = 1'b1;
                if (bus.rsa_eoc || timed_out) state_nxt = DONE;
            end
            DONE: begin
                done_v    = gnt_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q      <= '0;
            owner      <= '0;
            last_grant <= IDXW'(1);
            timer      <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            p_q        <= '0;
            e_q        <= '0;
            m_q        <= '0;
            k_q        <= '0;
        end else begin
            unique case (state)
                IDLE: if (|bus.req) begin
                    gnt_q <= arb_grant;
                    owner <= sel;
                    p_q   <= p_sel;
                    e_q   <= e_sel;
                    m_q   <= m_sel;
                    k_q   <= k_sel;
                end
                START: timer <= '0;
                RUN: begin
                    timer <= timer + TW'(1);
                    if (bus.rsa_eoc) begin
                        result_q <= bus.rsa_c;
                        err_q    <= 1'b0;
                    end else if (timed_out) begin
                        err_q <= 1'b1;
                    end
                end
                DONE: begin
                    last_grant <= owner;
                    gnt_q      <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_v;
    assign bus.result    = result_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state != IDLE);
    assign bus.rsa_ena   = ena;
    assign bus.rsa_clear = clear;
    assign bus.rsa_p     = p_q;
    assign bus.rsa_e     = e_q;
    assign bus.rsa_m     = m_q;
    assign bus.rsa_const = k_q;

endmodule

// File: tb/tb_rsa_scheduler.sv
// Scoreboard bench for rsa_scheduler with a stubbed datapath of programmable latency.
module tb_rsa_scheduler;

    localparam int unsigned WIDTH   = 8;
    localparam int          TIMEOUT = 64;
    localparam int          NEVER   = 1000;

    typedef struct {
        int         owner;
        logic [7:0] p, e, m, k;
        logic [7:0] result;
        logic       err;
        int         run_cycles;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rsa_scheduler_if #(.WIDTH(WIDTH)) bus ();

    rsa_scheduler #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    exp_t       exp_q[$];
    int         model_last   = 1;
    logic [7:0] model_result = 8'h00;
    int         stub_lat     = NEVER;
    logic [7:0] stub_cnt     = 8'h00;
    bit         allow_unqueued = 1'b0;

    function automatic logic [7:0] cipher(input logic [7:0] p, e, m, k);
        return p ^ (e + m) ^ k;
    endfunction

    // Datapath stub: eoc arrives stub_lat RUN cycles after the clear cycle.
    always @(posedge clk) begin
        if (bus.rsa_clear) stub_cnt <= 8'h00;
        else if (bus.rsa_ena && stub_cnt != 8'hFF) stub_cnt <= stub_cnt + 8'h01;
    end
    assign bus.rsa_eoc = bus.rsa_ena && !bus.rsa_clear && (int'(stub_cnt) == stub_lat);
    assign bus.rsa_c   = cipher(bus.rsa_p, bus.rsa_e, bus.rsa_m, bus.rsa_const);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        vectors++;
        if (act !== req_v) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req_v);
        end
    endtask

    // Reference model: round-robin owner, eoc-or-timeout outcome, held result.
    task automatic predict(input logic [1:0] r, input int lat, output exp_t x);
        int o;
        if (r == 2'b11) o = 1 - model_last;
        else            o = r[1] ? 1 : 0;
        x.owner      = o;
        x.p          = bus.p_in[o*8 +: 8];
        x.e          = bus.e_in[o*8 +: 8];
        x.m          = bus.m_in[o*8 +: 8];
        x.k          = bus.const_in[o*8 +: 8];
        x.err        = (lat > TIMEOUT - 1);
        x.run_cycles = x.err ? TIMEOUT : lat + 1;
        x.result     = x.err ? model_result : cipher(x.p, x.e, x.m, x.k);
        model_result = x.result;
        model_last   = o;
    endtask

    task automatic randomize_ops();
        bus.p_in     = 16'($urandom);
        bus.e_in     = 16'($urandom);
        bus.m_in     = 16'($urandom);
        bus.const_in = 16'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int w = 0;
        while (bus.done === 2'b00 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (bus.done === 2'b00) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got no done within %0d cycles, expected a done pulse", tag, w);
        end
    endtask

    task automatic run_job(input logic [1:0] r, input int lat, input bit drop_early, input bit p0_fix);
        exp_t x;
        predict(r, lat, x);
        exp_q.push_back(x);
        stub_lat = lat;
        bus.req  = r;
        @(negedge clk);
        check("accept_gnt", 32'(bus.gnt), 32'd1 << x.owner);
        check("accept_clear", 32'(bus.rsa_clear), 32'd1);
        if (drop_early) bus.req = 2'b00;
        randomize_ops();
        if (p0_fix) bus.p_in[7:0] = 8'h22;
        wait_done("job_done");
        bus.req = 2'b00;
        @(negedge clk);
        check("idle_after_done", 32'(bus.busy), 32'd0);
    endtask

    // Monitor: checks acceptance against the queue head and pops on every done.
    initial begin
        int   run_cnt   = 0;
        int   clear_cnt = 0;
        exp_t x;
        forever begin
            @(negedge clk);
            if (rst) begin
                run_cnt   = 0;
                clear_cnt = 0;
            end else begin
                if (bus.rsa_clear) begin
                    clear_cnt++;
                    run_cnt = 0;
                    if (exp_q.size() == 0) begin
                        if (!allow_unqueued) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected_start: got rsa_clear=1, expected no job");
                        end
                    end else begin
                        x = exp_q[0];
                        check("start_gnt", 32'(bus.gnt), 32'd1 << x.owner);
                        check("start_ena", 32'(bus.rsa_ena), 32'd1);
                        check("start_ops", {bus.rsa_p, bus.rsa_e, bus.rsa_m, bus.rsa_const},
                              {x.p, x.e, x.m, x.k});
                    end
                end else if (bus.rsa_ena) begin
                    run_cnt++;
                end
                if (bus.done !== 2'b00) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_done: got done=0x%0h, expected 0x0", bus.done);
                    end else begin
                        x = exp_q.pop_front();
                        check("done_owner", 32'(bus.done), 32'd1 << x.owner);
                        check("done_gnt", 32'(bus.gnt), 32'd1 << x.owner);
                        check("done_result", 32'(bus.result), 32'(x.result));
                        check("done_err", 32'(bus.err), 32'(x.err));
                        check("run_cycles", 32'(run_cnt), 32'(x.run_cycles));
                        check("done_ena_low", 32'(bus.rsa_ena), 32'd0);
                        check("clear_pulses", 32'(clear_cnt), 32'd1);
                        check("held_p", 32'(bus.rsa_p), 32'(x.p));
                    end
                    clear_cnt = 0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test by 1ms, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t x;
        int   gap;
        bus.req      = 2'b00;
        bus.p_in     = '0;
        bus.e_in     = '0;
        bus.m_in     = '0;
        bus.const_in = '0;

        #3;
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ena_clear", {30'd0, bus.rsa_ena, bus.rsa_clear}, 32'd0);
        check("rst_result_err", {23'd0, bus.err, bus.result}, 32'd0);
        check("rst_ops", {bus.rsa_p, bus.rsa_e, bus.rsa_m, bus.rsa_const}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single requester, eoc after 20 -> 0x5A; slot 0 p changes mid-run.
        bus.p_in     = {8'h00, 8'h11};
        bus.e_in     = {8'h00, 8'h20};
        bus.m_in     = {8'h00, 8'h2B};
        bus.const_in = '0;
        run_job(2'b01, 20, 1'b0, 1'b1);

        // Datapath never finishes: watchdog error, result held.
        randomize_ops();
        run_job(2'b01, NEVER, 1'b0, 1'b0);

        // eoc/timeout boundaries.
        randomize_ops();
        run_job(2'b10, 63, 1'b0, 1'b0);
        randomize_ops();
        run_job(2'b10, 62, 1'b1, 1'b0);
        randomize_ops();
        run_job(2'b01, 64, 1'b0, 1'b0);
        randomize_ops();
        run_job(2'b11, 0, 1'b1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            logic [1:0] r;
            int         lat;
            randomize_ops();
            r   = 2'($urandom_range(1, 3));
            lat = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 70));
            run_job(r, lat, 1'($urandom_range(0, 1)), 1'b0);
        end

        // Asynchronous reset ten cycles into RUN.
        allow_unqueued = 1'b1;
        randomize_ops();
        stub_lat = NEVER;
        bus.req  = 2'b01;
        @(negedge clk);
        bus.req = 2'b00;
        repeat (10) @(negedge clk);
        check("busy_before_rst", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_gnt_done", {28'd0, bus.gnt, bus.done}, 32'd0);
        check("arst_busy_ena", {29'd0, bus.busy, bus.rsa_ena, bus.rsa_clear}, 32'd0);
        check("arst_result_err", {23'd0, bus.err, bus.result}, 32'd0);
        check("arst_ops", {bus.rsa_p, bus.rsa_e, bus.rsa_m, bus.rsa_const}, 32'd0);
        model_last   = 1;
        model_result = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        allow_unqueued = 1'b0;
        repeat (4) @(negedge clk);

        // Both requesters held for four jobs: 0,1,0,1 with one IDLE cycle between.
        randomize_ops();
        stub_lat = 5;
        for (int k = 0; k < 4; k++) begin
            predict(2'b11, 5, x);
            exp_q.push_back(x);
        end
        bus.req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            wait_done("held_done");
            if (k == 3) begin
                bus.req = 2'b00;
            end else begin
                gap = 0;
                do begin
                    @(negedge clk);
                    gap++;
                end while (bus.rsa_clear !== 1'b1 && gap < 10);
                check("rr_gap", 32'(gap), 32'd2);
            end
        end
        @(negedge clk);
        check("idle_end", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rsa_scheduler.md
RSA_SCHEDULER -- requirements
Module: rsa_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width, matching the RSA datapath it drives.
REQ-002 SHALL have parameter TIMEOUT, default 1023: maximum RUN cycles before a job is aborted with error.
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  2  per-requester job request, level, bit i = requester i.
REQ-006 SHALL have port p_in, e_in, m_in, const_in  input  2*WIDTH each  per-requester operands, slot i at [i*WIDTH +: WIDTH].
REQ-007 SHALL have port gnt  output  2  one-hot owner of the datapath, high from acceptance through DONE.
REQ-008 SHALL have port done  output  2  one-cycle completion pulse to the owner.
REQ-009 SHALL have port result  output  WIDTH  last captured ciphertext, held until the next done.
REQ-010 SHALL have port err  output  1  timeout flag for the last job, valid with done, held with result.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port rsa_ena, rsa_clear  output  1 each  enable and one-cycle start/clear to the datapath (clear active-high).
REQ-013 SHALL have port rsa_p, rsa_e, rsa_m, rsa_const  output  WIDTH each  latched operands of the current job.
REQ-014 SHALL have port rsa_c  input  WIDTH  and rsa_eoc  input  1  datapath result and end-of-conversion.

Function
REQ-015 SHALL implement FSM IDLE -> START -> RUN -> DONE -> IDLE.
REQ-016 IDLE: if any req bit high, SHALL select an owner, latch its four operands, set gnt[owner] and go to START on the next edge; else stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: if both requests are high, the requester not granted last wins; last_grant resets to 1, so requester 0 wins first.
REQ-018 START: rsa_ena=1 and rsa_clear=1 for exactly one cycle, timer cleared to 0; rsa_eoc SHALL be ignored in this cycle.
REQ-019 RUN: rsa_ena=1, rsa_clear=0; timer increments each cycle, width $clog2(TIMEOUT+1).
REQ-020 RUN: on rsa_eoc=1, SHALL capture rsa_c into result, set err=0 and go to DONE.
REQ-021 RUN: if timer reaches TIMEOUT-1 with rsa_eoc=0, SHALL set err=1, leave result unchanged and go to DONE; if eoc and timeout coincide, eoc wins.
REQ-022 DONE: done[owner]=1 for one cycle, rsa_ena=0; update last_grant=owner; clear gnt; return to IDLE.
REQ-023 Latency: a req sampled high in IDLE at edge N SHALL give gnt and rsa_clear high after edge N, and rsa_ena high from edge N through the cycle eoc is seen.
REQ-024 A requester may drop req any time after gnt; the job SHALL still complete and pulse done (no abort).
REQ-025 req dropped before acceptance SHALL launch no job; req held high after done SHALL be treated as a new request in IDLE.
REQ-026 Changes on p_in/e_in/m_in/const_in after acceptance SHALL NOT affect rsa_* operand outputs until the next acceptance.
REQ-027 rsa_ena SHALL be 0 in IDLE and DONE.

Reset
REQ-028 On rst: state=IDLE, gnt=0, done=0, busy=0, rsa_ena=0, rsa_clear=0, result=0, err=0, rsa_* operands=0, timer=0, last_grant=1.
REQ-029 Reset mid-job SHALL take effect immediately (asynchronous) with no done pulse for the aborted job.

Structure
REQ-030 Package rsa_sched_pkg SHALL hold the state enum and NREQ=2 constant.
REQ-031 Round-robin selection SHALL be a sub-module rsa_rr_arbiter (req, last_grant -> one-hot grant), combinational.

Verification (datapath stubbed: eoc N cycles after clear, returns fixed C)
REQ-032 req=01, stub N=20, C=0x5A -> gnt=01 next cycle, one rsa_clear pulse, done=01 after 21 RUN cycles, result=0x5A, err=0.
REQ-033 req=11 first job after reset -> requester 0 served first, then requester 1 without gap beyond one IDLE cycle.
REQ-034 req=11 held, 4 jobs -> grant order 0,1,0,1; each done matches owner.
REQ-035 TIMEOUT=64, stub never asserts eoc -> done after 64 RUN cycles, err=1, result unchanged, rsa_ena low in DONE.
REQ-036 rst pulsed 10 cycles into RUN -> all outputs at reset values immediately, no done, next req accepted normally.
REQ-037 p_in slot 0 changed from 0x11 to 0x22 during RUN -> rsa_p stays 0x11 until next acceptance.
